// File: rtl/ldm_stm_sequencer_if.sv
// Bus bundle for ldm_stm_sequencer: transfer request, register-file ports,
// memory port and status. The sequencer is the master side.
interface ldm_stm_sequencer_if;
  logic        start;
  logic        is_load;
  logic        up;
  logic [15:0] reglist;
  logic [3:0]  rn;
  logic [31:0] base_addr;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        pc_written;

  modport master (
    input  start, is_load, up, reglist, rn, base_addr, rf_rdata, mem_ack, mem_rdata,
    output rf_raddr, rf_we, rf_waddr, rf_wdata, mem_req, mem_we, mem_addr, mem_wdata,
           busy, done, pc_written
  );

  modport slave (
    output start, is_load, up, reglist, rn, base_addr, rf_rdata, mem_ack, mem_rdata,
    input  rf_raddr, rf_we, rf_waddr, rf_wdata, mem_req, mem_we, mem_addr, mem_wdata,
           busy, done, pc_written
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Sequences LDM/STM multi-register transfers over a single memory port.
// Base-register writeback is built only when LDM_STM_BASE_WB_EN is defined.
module ldm_stm_sequencer #(
  parameter int WORD_BYTES = 4
) (
  input logic                 clk,
  input logic                 reset,
  ldm_stm_sequencer_if.master bus
);

`ifdef LDM_STM_BASE_WB_EN
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WB = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd3} state_t;
`endif

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, m[i]};
    return cnt;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  state_t      state_r, state_n;
  logic [15:0] mask_r;
  logic [4:0]  count_r;
  logic [31:0] addr_r;
  logic        is_load_r;
`ifdef LDM_STM_BASE_WB_EN
  logic [3:0]  rn_r;
  logic [31:0] wb_addr_r;
  logic        wb_skip_r;
`endif

  logic [4:0]  start_count_s;
  logic [31:0] span_s;
  logic [3:0]  cur_reg_s;
  logic        last_ack_s;

  assign start_count_s = popcount16(bus.reglist);
  assign span_s        = STRIDE * {27'd0, start_count_s};
  assign cur_reg_s     = lowest_set(mask_r);
  assign last_ack_s    = bus.mem_ack && (count_r == 5'd1);

  // Next state and all bus outputs; everything is held low while reset is high.
  always_comb begin
    state_n        = state_r;
    bus.rf_raddr   = 4'd0;
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = 4'd0;
    bus.rf_wdata   = 32'd0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.pc_written = 1'b0;
    if (reset) begin
      state_n = IDLE;
    end else begin
      bus.busy = (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (bus.start) state_n = (start_count_s == 5'd0) ? DONE : XFER;
          else           state_n = IDLE;
        end
        XFER: begin
          bus.mem_req  = 1'b1;
          bus.mem_we   = !is_load_r;
          bus.mem_addr = addr_r;
          if (!is_load_r) begin
            bus.rf_raddr  = cur_reg_s;
            bus.mem_wdata = bus.rf_rdata;
          end else if (bus.mem_ack) begin
            bus.rf_we      = 1'b1;
            bus.rf_waddr   = cur_reg_s;
            bus.rf_wdata   = bus.mem_rdata;
            bus.pc_written = (cur_reg_s == 4'd15);
          end else begin
            bus.rf_we = 1'b0;
          end
          if (last_ack_s) begin
`ifdef LDM_STM_BASE_WB_EN
            state_n = wb_skip_r ? DONE : WB;
`else
            state_n = DONE;
`endif
          end else begin
            state_n = XFER;
          end
        end
`ifdef LDM_STM_BASE_WB_EN
        WB: begin
          bus.rf_we    = 1'b1;
          bus.rf_waddr = rn_r;
          bus.rf_wdata = wb_addr_r;
          state_n      = DONE;
        end
`endif
        DONE: begin
          bus.done = 1'b1;
          state_n  = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register plus transfer context: latched on accept, stepped per ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      mask_r    <= 16'd0;
      count_r   <= 5'd0;
      addr_r    <= 32'd0;
      is_load_r <= 1'b0;
`ifdef LDM_STM_BASE_WB_EN
      rn_r      <= 4'd0;
      wb_addr_r <= 32'd0;
      wb_skip_r <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      if (state_r == IDLE && bus.start) begin
        mask_r    <= bus.reglist;
        count_r   <= start_count_s;
        is_load_r <= bus.is_load;
        addr_r    <= bus.up ? bus.base_addr : bus.base_addr - span_s;
`ifdef LDM_STM_BASE_WB_EN
        rn_r      <= bus.rn;
        wb_addr_r <= bus.up ? bus.base_addr + span_s : bus.base_addr - span_s;
        wb_skip_r <= bus.is_load && bus.reglist[bus.rn];
`endif
      end else if (state_r == XFER && bus.mem_ack) begin
        mask_r  <= mask_r & ~(16'd1 << cur_reg_s);
        count_r <= count_r - 5'd1;
        addr_r  <= addr_r + STRIDE;
      end
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: expected memory accesses and register
// writes are queued when a transfer is launched and popped as the DUT performs them.
module tb_ldm_stm_sequencer;
  localparam int WBYTES = 4;
`ifdef LDM_STM_BASE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif
  localparam logic [31:0] KEY = 32'hC0DE_0000;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } mem_ev_t;
  typedef struct { logic [3:0] idx; logic [31:0] data; logic pc; } rf_ev_t;

  logic clk = 1'b0;
  logic reset;
  ldm_stm_sequencer_if bus();

  ldm_stm_sequencer #(.WORD_BYTES(WBYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  mem_ev_t     exp_mem[$];
  rf_ev_t      exp_rf[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] rf_model [16];

  // Memory model: acks after ack_delay waiting cycles, load data derived from address.
  assign bus.rf_rdata  = rf_model[bus.rf_raddr];
  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
  assign bus.mem_rdata = bus.mem_addr ^ KEY;

  always @(posedge clk) begin
    if (reset || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      n_checks++;
      if (exp_mem.size() == 0) begin
        n_fail++;
        $display("FAIL mem_unexpected: got mem_req with addr=%h, want no request", bus.mem_addr);
      end else begin
        if (bus.mem_addr !== exp_mem[0].addr || bus.mem_we !== exp_mem[0].we ||
            (exp_mem[0].we && bus.mem_wdata !== exp_mem[0].data)) begin
          n_fail++;
          $display("FAIL mem_access: got addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                   bus.mem_addr, bus.mem_we, bus.mem_wdata,
                   exp_mem[0].addr, exp_mem[0].we, exp_mem[0].data);
        end
        if (bus.mem_ack === 1'b1) void'(exp_mem.pop_front());
      end
    end
    if (bus.rf_we === 1'b1) begin
      n_checks++;
      if (exp_rf.size() == 0) begin
        n_fail++;
        $display("FAIL rf_unexpected: got rf write R%0d=%h, want no write", bus.rf_waddr, bus.rf_wdata);
      end else begin
        if (bus.rf_waddr !== exp_rf[0].idx || bus.rf_wdata !== exp_rf[0].data ||
            bus.pc_written !== exp_rf[0].pc) begin
          n_fail++;
          $display("FAIL rf_write: got R%0d=%h pc=%b, want R%0d=%h pc=%b",
                   bus.rf_waddr, bus.rf_wdata, bus.pc_written,
                   exp_rf[0].idx, exp_rf[0].data, exp_rf[0].pc);
        end
        void'(exp_rf.pop_front());
      end
    end else if (bus.pc_written === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL pc_written_alone: got pc_written=1 with rf_we=0, want 0");
    end
  end

  task automatic exp_m(input logic [31:0] a, input logic we, input logic [31:0] d);
    exp_mem.push_back(mem_ev_t'{a, we, d});
  endtask

  task automatic exp_r(input logic [3:0] idx, input logic [31:0] d, input logic pc);
    exp_rf.push_back(rf_ev_t'{idx, d, pc});
  endtask

  task automatic push_model(input logic ld, input logic u, input logic [15:0] rl,
                            input logic [3:0] r, input logic [31:0] base, output int exp_cycles);
    int n;
    logic [31:0] a;
    logic wb;
    n = 0;
    for (int i = 0; i < 16; i++) if (rl[i]) n++;
    a = u ? base : base - 32'(WBYTES * n);
    for (int i = 0; i < 16; i++) begin
      if (rl[i]) begin
        exp_m(a, !ld, ld ? 32'd0 : rf_model[i]);
        if (ld) exp_r(4'(i), a ^ KEY, (i == 15) ? 1'b1 : 1'b0);
        a = a + 32'(WBYTES);
      end
    end
    wb = WB_EN && (n > 0) && !(ld && rl[r]);
    if (wb) exp_r(r, u ? base + 32'(WBYTES * n) : base - 32'(WBYTES * n), 1'b0);
    exp_cycles = (n == 0) ? 1 : n + (wb ? 1 : 0) + 1;
  endtask

  task automatic drive(input logic ld, input logic u, input logic [15:0] rl,
                       input logic [3:0] r, input logic [31:0] base);
    bus.is_load   = ld;
    bus.up        = u;
    bus.reglist   = rl;
    bus.rn        = r;
    bus.base_addr = base;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Returns the cycle index (start cycle = 0) at which done is seen, or -1.
  task automatic wait_done(input int k0, input int budget, output int cycles);
    int k;
    k = k0;
    cycles = -1;
    while (k <= budget) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cycles = k;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 4'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.rf_we !== 1'b0 || bus.pc_written !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got mem_req=%b rf_we=%b pc_written=%b, want 0 0 0",
               bus.mem_req, bus.rf_we, bus.pc_written);
    end
    n_checks++;
    if (bus.mem_addr !== 32'd0 || bus.rf_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got mem_addr=%h rf_wdata=%h, want 0 0", bus.mem_addr, bus.rf_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_up();
    int cyc;
    ack_delay = 0;
    exp_m(32'h0000_0100, 1'b0, 32'd0);
    exp_r(4'd1, 32'h0000_0100 ^ KEY, 1'b0);
    exp_m(32'h0000_0104, 1'b0, 32'd0);
    exp_r(4'd2, 32'h0000_0104 ^ KEY, 1'b0);
    if (WB_EN) exp_r(4'd0, 32'h0000_0108, 1'b0);
    drive(1'b1, 1'b1, 16'h0006, 4'd0, 32'h0000_0100);
    pulse_start();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_up_busy: got busy=%b, want 1", bus.busy);
    end
    wait_done(1, 20, cyc);
    n_checks++;
    if (cyc != (WB_EN ? 4 : 3)) begin
      n_fail++;
      $display("FAIL load_up_latency: got done at cycle %0d, want %0d", cyc, WB_EN ? 4 : 3);
    end
    n_checks++;
    if (exp_mem.size() != 0 || exp_rf.size() != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_up_end: got pending mem=%0d rf=%0d busy=%b done=%b, want 0 0 0 0",
               exp_mem.size(), exp_rf.size(), bus.busy, bus.done);
    end
    exp_mem.delete();
    exp_rf.delete();
  endtask

  task automatic test_store_down();
    int cyc;
    exp_m(32'h0000_01F8, 1'b1, rf_model[0]);
    exp_m(32'h0000_01FC, 1'b1, rf_model[15]);
    if (WB_EN) exp_r(4'd13, 32'h0000_01F8, 1'b0);
    drive(1'b0, 1'b0, 16'h8001, 4'd13, 32'h0000_0200);
    pulse_start();
    wait_done(1, 20, cyc);
    n_checks++;
    if (cyc != (WB_EN ? 4 : 3)) begin
      n_fail++;
      $display("FAIL store_down_latency: got done at cycle %0d, want %0d", cyc, WB_EN ? 4 : 3);
    end
    n_checks++;
    if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
      n_fail++;
      $display("FAIL store_down_end: got pending mem=%0d rf=%0d, want 0 0", exp_mem.size(), exp_rf.size());
    end
    exp_mem.delete();
    exp_rf.delete();
  endtask

  task automatic test_empty();
    int cyc;
    drive(1'b1, 1'b1, 16'h0000, 4'd2, 32'h0000_0500);
    pulse_start();
    wait_done(1, 10, cyc);
    n_checks++;
    if (cyc != 1) begin
      n_fail++;
      $display("FAIL empty_latency: got done at cycle %0d, want 1", cyc);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_end: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_load_rn_in_list();
    int cyc;
    exp_m(32'h0000_0300, 1'b0, 32'd0);
    exp_r(4'd4, 32'h0000_0300 ^ KEY, 1'b0);
    exp_m(32'h0000_0304, 1'b0, 32'd0);
    exp_r(4'd15, 32'h0000_0304 ^ KEY, 1'b1);
    drive(1'b1, 1'b1, 16'h8010, 4'd4, 32'h0000_0300);
    pulse_start();
    wait_done(1, 20, cyc);
    n_checks++;
    if (cyc != 3) begin
      n_fail++;
      $display("FAIL rn_in_list_latency: got done at cycle %0d, want 3", cyc);
    end
    n_checks++;
    if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
      n_fail++;
      $display("FAIL rn_in_list_end: got pending mem=%0d rf=%0d, want 0 0", exp_mem.size(), exp_rf.size());
    end
    exp_mem.delete();
    exp_rf.delete();
  endtask

  task automatic test_delayed_ignore_start();
    int cyc;
    ack_delay = 2;
    exp_m(32'h0000_0600, 1'b0, 32'd0);
    exp_r(4'd0, 32'h0000_0600 ^ KEY, 1'b0);
    exp_m(32'h0000_0604, 1'b0, 32'd0);
    exp_r(4'd1, 32'h0000_0604 ^ KEY, 1'b0);
    if (WB_EN) exp_r(4'd7, 32'h0000_0608, 1'b0);
    drive(1'b1, 1'b1, 16'h0003, 4'd7, 32'h0000_0600);
    pulse_start();
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'hFFFF, 4'd9, 32'h0000_0000);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.mem_addr !== 32'h0000_0600) begin
      n_fail++;
      $display("FAIL stall_hold: got busy=%b mem_addr=%h, want 1 00000600", bus.busy, bus.mem_addr);
    end
    wait_done(3, 40, cyc);
    n_checks++;
    if (cyc != (WB_EN ? 8 : 7)) begin
      n_fail++;
      $display("FAIL delayed_latency: got done at cycle %0d, want %0d", cyc, WB_EN ? 8 : 7);
    end
    n_checks++;
    if (exp_mem.size() != 0 || exp_rf.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL delayed_end: got pending mem=%0d rf=%0d busy=%b, want 0 0 0",
               exp_mem.size(), exp_rf.size(), bus.busy);
    end
    exp_mem.delete();
    exp_rf.delete();
    ack_delay = 0;
  endtask

  task automatic test_reset_abort();
    int cyc;
    ack_delay = 3;
    drive(1'b0, 1'b1, 16'h0007, 4'd3, 32'h0000_0400);
    push_model(1'b0, 1'b1, 16'h0007, 4'd3, 32'h0000_0400, cyc);
    pulse_start();
    repeat (5) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_mem.size() != 2 || bus.mem_addr !== 32'h0000_0404) begin
      n_fail++;
      $display("FAIL abort_progress: got pending=%0d mem_addr=%h, want 2 00000404",
               exp_mem.size(), bus.mem_addr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_mem.delete();
    exp_rf.delete();
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got mem_req=%b busy=%b rf_we=%b, want 0 0 0",
               bus.mem_req, bus.busy, bus.rf_we);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    ack_delay = 0;
  endtask

  task automatic test_back_to_back();
    int cyc, want;
    logic ld, u;
    logic [15:0] rl;
    logic [3:0] r;
    logic [31:0] base;
    for (int t = 0; t < 6; t++) begin
      if (t == 0) begin
        ld = 1'b0; u = 1'b0; rl = 16'h0007; r = 4'd1; base = 32'h0000_0004;
      end else begin
        ld = 1'($urandom_range(0, 1));
        u = 1'($urandom_range(0, 1));
        rl = 16'($urandom_range(0, 65535));
        r = 4'($urandom_range(0, 15));
        base = $urandom() & 32'hFFFF_FFFC;
      end
      drive(ld, u, rl, r, base);
      push_model(ld, u, rl, r, base, want);
      pulse_start();
      wait_done(1, 40, cyc);
      n_checks++;
      if (cyc != want) begin
        n_fail++;
        $display("FAIL b2b_latency[%0d]: got done at cycle %0d, want %0d (reglist=%h)", t, cyc, want, rl);
      end
      n_checks++;
      if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
        n_fail++;
        $display("FAIL b2b_end[%0d]: got pending mem=%0d rf=%0d, want 0 0", t, exp_mem.size(), exp_rf.size());
      end
      exp_mem.delete();
      exp_rf.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_model[i] = 32'h1000_0000 + 32'(i * 16'h0111);
    reset = 1'b1;
    bus.start = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 4'd0, 32'd0);
    test_reset();
    test_load_up();
    test_store_down();
    test_empty();
    test_load_rn_in_list();
    test_delayed_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
